// File: rtl/chord_song_reader.sv
// Song ROM walker: fetches entries for the selected song, issues chord notes downstream
// under voice back-pressure, and times advance entries in beats.
module chord_song_reader #(
  parameter int unsigned SONG_BITS = 2,
  parameter int unsigned IDX_BITS  = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          play_enable,
  input  logic [SONG_BITS-1:0]          song,
  input  logic                          beat,
  input  logic                          voice_available,
  output logic [SONG_BITS+IDX_BITS-1:0] rom_addr,
  input  logic [12:0]                   rom_data,
  output logic [5:0]                    note_to_load,
  output logic [5:0]                    duration,
  output logic                          load_new_note,
  output logic                          song_done
);
  localparam int unsigned FIELD_BITS = 6;
  localparam int unsigned ENTRY_BITS = 2 * FIELD_BITS;

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, ISSUE, WAIT_BEATS, DONE} state_t;

  state_t                state;
  logic [IDX_BITS-1:0]   idx;
  logic [SONG_BITS-1:0]  song_q;
  logic [FIELD_BITS-1:0] count;
  logic [ENTRY_BITS-1:0] entry;

  logic                  rom_adv;
  logic [FIELD_BITS-1:0] rom_note;
  logic [FIELD_BITS-1:0] rom_dur;
  logic                  running;
  logic                  abort;
  logic                  last_idx;
  logic                  step;
  logic [IDX_BITS-1:0]   idx_inc;

  assign rom_adv  = rom_data[12];
  assign rom_note = rom_data[11:6];
  assign rom_dur  = rom_data[5:0];
  assign running  = (state != IDLE) && (state != DONE);
  assign abort    = running && (song != song_q);
  assign last_idx = (idx == '1);
  assign idx_inc  = idx + IDX_BITS'(1);

  // Strobe is suppressed by reset, pause and a pending song change.
  assign load_new_note = !reset && !abort && play_enable && voice_available && (state == ISSUE);
  assign note_to_load  = load_new_note ? entry[11:6] : '0;
  assign duration      = load_new_note ? entry[5:0]  : '0;

  // Current entry retires this cycle: move to the next index, or finish after the last one.
  always_comb begin
    step = 1'b0;
    if (!abort && play_enable) begin
      case (state)
        DECODE:     step = (rom_adv && rom_dur == '0) ||
                           (!rom_adv && rom_note == '0 && rom_dur != '0);
        ISSUE:      step = voice_available;
        WAIT_BEATS: step = beat && (count <= FIELD_BITS'(1));
        default:    step = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      song_q    <= '0;
      count     <= '0;
      entry     <= '0;
      rom_addr  <= '0;
      song_done <= 1'b0;
    end else if (abort) begin
      state    <= FETCH;
      idx      <= '0;
      song_q   <= song;
      count    <= '0;
      rom_addr <= {song, IDX_BITS'(0)};
    end else begin
      case (state)
        IDLE: begin
          idx <= '0;
          if (play_enable) begin
            song_q   <= song;
            rom_addr <= {song, IDX_BITS'(0)};
            state    <= FETCH;
          end
        end
        FETCH: if (play_enable) state <= DECODE;
        DECODE: if (play_enable) begin
          entry <= rom_data[11:0];
          if (rom_data == '0) begin
            state     <= DONE;
            song_done <= 1'b1;
          end else if (rom_adv && rom_dur != '0) begin
            count <= rom_dur;
            state <= WAIT_BEATS;
          end else if (!rom_adv && rom_note != '0) begin
            state <= ISSUE;
          end
        end
        WAIT_BEATS: if (play_enable && beat) count <= count - FIELD_BITS'(1);
        DONE: if (!play_enable) begin
          state     <= IDLE;
          song_done <= 1'b0;
          idx       <= '0;
          rom_addr  <= {song_q, IDX_BITS'(0)};
        end
        default: ;
      endcase
      if (step) begin
        if (last_idx) begin
          state     <= DONE;
          song_done <= 1'b1;
        end else begin
          idx      <= idx_inc;
          rom_addr <= {song_q, idx_inc};
          state    <= FETCH;
        end
      end
    end
  end
endmodule

// File: tb/tb_chord_song_reader.sv
// Scoreboard bench for chord_song_reader: bench-side ROM, expected-note queue, cycle-timing checks.
module tb_chord_song_reader;
  localparam int unsigned SONG_BITS = 2;
  localparam int unsigned IDX_BITS  = 5;
  localparam int unsigned ADDR_BITS = SONG_BITS + IDX_BITS;
  localparam int unsigned DEPTH     = 1 << ADDR_BITS;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 play_enable;
  logic [SONG_BITS-1:0] song;
  logic                 beat;
  logic                 voice_available;
  logic [ADDR_BITS-1:0] rom_addr;
  logic [12:0]          rom_data;
  logic [5:0]           note_to_load;
  logic [5:0]           duration;
  logic                 load_new_note;
  logic                 song_done;

  typedef struct packed {logic [5:0] note; logic [5:0] dur;} strobe_t;

  logic [12:0] rom [DEPTH];
  strobe_t     exp_q[$];
  strobe_t     mon_e;
  int          strobe_cyc[$];
  int          pe_beats[$];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          beat_mode = 0;

  chord_song_reader #(.SONG_BITS(SONG_BITS), .IDX_BITS(IDX_BITS)) dut (
    .clk(clk), .reset(reset), .play_enable(play_enable), .song(song), .beat(beat),
    .voice_available(voice_available), .rom_addr(rom_addr), .rom_data(rom_data),
    .note_to_load(note_to_load), .duration(duration), .load_new_note(load_new_note),
    .song_done(song_done));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every strobe and records beat/strobe timing.
  always @(negedge clk) begin
    if (beat && play_enable && !reset) pe_beats.push_back(cyc);
    if (load_new_note) begin
      strobe_cyc.push_back(cyc);
      check("strobe_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("strobe_note", 32'(note_to_load), 32'(mon_e.note));
        check("strobe_dur", 32'(duration), 32'(mon_e.dur));
      end
    end else begin
      check("idle_fields_zero", 32'({note_to_load, duration}), 0);
    end
  end

  function automatic logic [12:0] ent(input bit adv, input int note, input int dur);
    return {adv, 6'(note), 6'(dur)};
  endfunction

  function automatic int addr_of(input int s, input int i);
    return s * (1 << IDX_BITS) + i;
  endfunction

  function automatic int sc(input int i);
    return (strobe_cyc.size() > i) ? strobe_cyc[i] : -1;
  endfunction

  function automatic int count_from(input int from);
    int n = 0;
    foreach (pe_beats[i]) if (pe_beats[i] >= from) n++;
    return n;
  endfunction

  function automatic int kth_beat(input int from, input int k);
    int n = 0;
    foreach (pe_beats[i]) begin
      if (pe_beats[i] >= from) begin
        n++;
        if (n == k) return pe_beats[i];
      end
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    case (beat_mode)
      1:       beat = (cyc % 4 == 0);
      2:       beat = ($urandom_range(0, 2) == 0);
      default: beat = 1'b0;
    endcase
  endtask

  task automatic do_reset();
    reset = 1'b1; play_enable = 1'b0; voice_available = 1'b0; song = '0; beat_mode = 0;
    step();
    step();
    reset = 1'b0;
    exp_q.delete(); strobe_cyc.delete(); pe_beats.delete();
  endtask

  task automatic start_song(input int s, output int c0);
    step();
    song = SONG_BITS'(s);
    play_enable = 1'b1;
    c0 = cyc;
  endtask

  task automatic wait_done(input int budget, input string name, output int done_at);
    int n = 0;
    while (!song_done && n < budget) begin
      step();
      n++;
    end
    check({name, "_done_in_budget"}, 32'(song_done), 1);
    done_at = song_done ? cyc : -1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, d, n, bad, s, len, kind, nt, du, sw;
    logic [12:0] w;
    logic [ADDR_BITS-1:0] held;
    foreach (rom[i]) rom[i] = '0;
    beat = 1'b0;

    // Reset state
    do_reset();
    reset = 1'b1;
    step();
    check("rst_rom_addr", 32'(rom_addr), 0);
    check("rst_load", 32'(load_new_note), 0);
    check("rst_fields", 32'({note_to_load, duration}), 0);
    check("rst_song_done", 32'(song_done), 0);

    // Chord issue: three strobes 3 cycles apart, 12 beats of silence, then done
    do_reset();
    rom[addr_of(1, 0)] = ent(0, 20, 12);
    rom[addr_of(1, 1)] = ent(0, 24, 12);
    rom[addr_of(1, 2)] = ent(0, 27, 12);
    rom[addr_of(1, 3)] = ent(1, 0, 12);
    rom[addr_of(1, 4)] = '0;
    exp_q.push_back('{6'd20, 6'd12});
    exp_q.push_back('{6'd24, 6'd12});
    exp_q.push_back('{6'd27, 6'd12});
    voice_available = 1'b1; beat_mode = 1;
    start_song(1, c0);
    wait_done(400, "chord", d);
    check("chord_strobe_count", 32'(strobe_cyc.size()), 3);
    check("chord_strobe0_cyc", 32'(sc(0)), 32'(c0 + 3));
    check("chord_strobe1_cyc", 32'(sc(1)), 32'(c0 + 6));
    check("chord_strobe2_cyc", 32'(sc(2)), 32'(c0 + 9));
    check("chord_done_cyc", 32'(d), 32'(kth_beat(c0 + 12, 12) + 3));
    check("chord_drained", 32'(exp_q.size()), 0);

    // Back-pressure: five stalled ISSUE cycles, then exactly one strobe
    do_reset();
    rom[addr_of(3, 0)] = ent(0, 9, 7);
    rom[addr_of(3, 1)] = '0;
    exp_q.push_back('{6'd9, 6'd7});
    start_song(3, c0);
    while (cyc < c0 + 8) step();
    check("bp_no_early_strobe", 32'(strobe_cyc.size()), 0);
    voice_available = 1'b1;
    #1;
    check("bp_strobe_now", 32'(load_new_note), 1);
    wait_done(50, "bp", d);
    check("bp_strobe_cyc", 32'(sc(0)), 32'(c0 + 8));
    check("bp_strobe_count", 32'(strobe_cyc.size()), 1);
    check("bp_done_cyc", 32'(d), 32'(c0 + 11));

    // Pause during a 4-beat wait: paused beats are not counted, address frozen
    do_reset();
    rom[addr_of(0, 0)] = ent(1, 0, 4);
    rom[addr_of(0, 1)] = '0;
    voice_available = 1'b1; beat_mode = 1;
    start_song(0, c0);
    n = 0;
    while (count_from(c0 + 3) < 2 && n < 100) begin
      step();
      n++;
    end
    play_enable = 1'b0;
    held = rom_addr;
    repeat (12) step();
    check("pause_addr_frozen", 32'(rom_addr), 32'(held));
    check("pause_not_done", 32'(song_done), 0);
    play_enable = 1'b1;
    wait_done(200, "pause", d);
    check("pause_done_cyc", 32'(d), 32'(kth_beat(c0 + 3, 4) + 3));

    // Song change mid-wait restarts at entry 0 of the new song
    do_reset();
    rom[addr_of(0, 0)] = ent(1, 0, 40);
    rom[addr_of(0, 1)] = '0;
    rom[addr_of(2, 0)] = ent(0, 5, 1);
    rom[addr_of(2, 1)] = '0;
    voice_available = 1'b1; beat_mode = 1;
    start_song(0, c0);
    while (cyc < c0 + 10) step();
    song = 2'd2;
    sw = cyc;
    exp_q.push_back('{6'd5, 6'd1});
    step();
    check("chg_rom_addr", 32'(rom_addr), 32'(addr_of(2, 0)));
    wait_done(50, "chg", d);
    check("chg_strobe_cyc", 32'(sc(0)), 32'(sw + 3));
    check("chg_done_cyc", 32'(d), 32'(sw + 6));

    // Full song without end marker: finishes after the last index, never wraps
    do_reset();
    for (int i = 0; i < 32; i++) rom[addr_of(3, i)] = ent(1, 0, 0);
    start_song(3, c0);
    bad = 0; n = 0;
    while (!song_done && n < 200) begin
      step();
      n++;
      if (cyc >= c0 + 3 && rom_addr == ADDR_BITS'(addr_of(3, 0))) bad++;
    end
    check("full_done_cyc", song_done ? 32'(cyc) : 32'hFFFF_FFFF, 32'(c0 + 65));
    check("full_no_wrap", 32'(bad), 0);
    check("full_last_addr", 32'(rom_addr), 32'(addr_of(3, 31)));
    reset = 1'b1;
    step();
    check("rst_done_clear", 32'(song_done), 0);
    check("rst_done_addr", 32'(rom_addr), 0);

    // Reset mid-ISSUE with a voice free: no strobe, outputs cleared
    do_reset();
    voice_available = 1'b1;
    start_song(1, c0);
    while (cyc < c0 + 3) step();
    reset = 1'b1;
    #1;
    check("rst_issue_load", 32'(load_new_note), 0);
    step();
    check("rst_issue_addr", 32'(rom_addr), 0);
    check("rst_issue_load_next", 32'(load_new_note), 0);
    check("rst_issue_fields", 32'({note_to_load, duration}), 0);
    check("rst_issue_done", 32'(song_done), 0);

    // Random songs with random back-pressure, beats and pauses
    for (int t = 0; t < 8; t++) begin
      do_reset();
      s = $urandom_range(0, 3);
      len = $urandom_range(1, 10);
      for (int i = 0; i < len; i++) begin
        kind = $urandom_range(0, 2);
        case (kind)
          0: begin
            nt = $urandom_range(1, 63); du = $urandom_range(0, 63);
            w = ent(0, nt, du);
            exp_q.push_back('{6'(nt), 6'(du)});
          end
          1:       w = ent(0, 0, $urandom_range(1, 63));
          default: w = ent(1, $urandom_range(0, 63), $urandom_range(0, 6));
        endcase
        rom[addr_of(s, i)] = w;
      end
      rom[addr_of(s, len)] = '0;
      beat_mode = 2;
      start_song(s, c0);
      n = 0;
      while (!song_done && n < 3000) begin
        step();
        n++;
        voice_available = ($urandom_range(0, 3) != 0);
        play_enable = song_done || ($urandom_range(0, 7) != 0);
      end
      check("rand_done", 32'(song_done), 1);
      check("rand_drained", 32'(exp_q.size()), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/chord_song_reader.md
CHORD_SONG_READER -- requirements
Module: chord_song_reader

Interface
REQ-001 Parameter SONG_BITS, default 2, width of song select; number of songs is 2^SONG_BITS.
REQ-002 Parameter IDX_BITS, default 5, width of entry index; each song holds 2^IDX_BITS entries.
REQ-003 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 play_enable  input  1  high = run; low = pause in place.
REQ-006 song  input  SONG_BITS  selects the song to play.
REQ-007 beat  input  1  one-cycle 1/48 s beat tick.
REQ-008 voice_available  input  1  high = downstream chord player can accept a note this cycle.
REQ-009 rom_addr  output  SONG_BITS+IDX_BITS  registered {song_q, idx} address to the song ROM.
REQ-010 rom_data  input  13  ROM word, valid one cycle after rom_addr: [12] advance, [11:6] note, [5:0] duration.
REQ-011 note_to_load  output  6  note number presented with load_new_note.
REQ-012 duration  output  6  note duration in beats, presented with load_new_note.
REQ-013 load_new_note  output  1  one-cycle strobe issuing a note downstream.
REQ-014 song_done  output  1  high while the song has finished.

Function
REQ-015 States SHALL be IDLE, FETCH, DECODE, ISSUE, WAIT_BEATS, DONE.
REQ-016 IDLE: idx=0; with play_enable=1, latch song into song_q and go to FETCH.
REQ-017 FETCH: rom_addr={song_q, idx} is stable; next cycle go to DECODE (one-cycle ROM latency).
REQ-018 DECODE: latch rom_data into an entry register and branch per REQ-019..REQ-022.
REQ-019 rom_data==13'b0 is the end-of-song marker: go to DONE.
REQ-020 advance=1: load the wait counter with duration[5:0] and go to WAIT_BEATS; if duration==0, advance idx and go straight to FETCH.
REQ-021 advance=0, note!=0: go to ISSUE.
REQ-022 advance=0, note==0 (rest entry): issue nothing; advance idx and go to FETCH.
REQ-023 ISSUE: load_new_note = voice_available & play_enable, driven combinationally from state and the entry register.
REQ-024 ISSUE, while load_new_note=1: note_to_load and duration equal the entry fields; on that edge advance idx and go to FETCH.
REQ-025 ISSUE, voice_available=0: hold in ISSUE with the entry intact (no drop, no duplicate strobe).
REQ-026 When load_new_note=0, note_to_load and duration SHALL be 6'b0.
REQ-027 WAIT_BEATS: the counter decrements on each cycle with beat & play_enable.
REQ-028 WAIT_BEATS, counter reaching 0: advance idx and go to FETCH.
REQ-029 A beat coinciding with the DECODE cycle that loads the counter SHALL NOT be counted.
REQ-030 Index advance from 2^IDX_BITS-1 SHALL NOT wrap; go to DONE instead of FETCH.
REQ-031 DONE: song_done=1; remain in DONE until play_enable=0, then go to IDLE.
REQ-032 play_enable=0 in any state except IDLE/DONE freezes the state, idx and counter.
REQ-033 During a pause, load_new_note SHALL be 0.
REQ-034 song differing from song_q in any state other than IDLE/DONE aborts the current song.
REQ-035 On abort: next cycle idx=0, song_q=song, state=FETCH, and the wait counter is cleared.
REQ-036 Song change takes priority over every other transition in the same cycle.
REQ-037 Per ROM entry, latency from the FETCH edge to the load_new_note strobe SHALL be 2 cycles when voice_available=1.

Reset
REQ-038 reset=1 SHALL force: state=IDLE, idx=0, song_q=0, counter=0, load_new_note=0, note_to_load=0, duration=0, song_done=0, rom_addr=0.
REQ-039 reset SHALL override play_enable, song change and beat in the same cycle, including mid-WAIT_BEATS and mid-ISSUE.

Verification
REQ-040 Scenario, chord issue: song 1 = {note 20 dur 12, note 24 dur 12, note 27 dur 12, adv dur 12, 0}, voice_available=1 -> three strobes exactly 3 cycles apart with (20,12),(24,12),(27,12), then 12 beats of silence, then song_done=1.
REQ-041 Scenario, back-pressure: voice_available=0 for 5 cycles in ISSUE -> no strobe; single strobe on the first cycle voice_available=1, outputs unchanged.
REQ-042 Scenario, pause: play_enable=0 for 3 beats during adv dur 4 -> total wait = 4 counted beats plus the paused time; rom_addr frozen.
REQ-043 Scenario, song change: song 0->2 mid-WAIT_BEATS -> next cycle rom_addr={2,0}, state FETCH.
REQ-044 Scenario, full song without end marker: 32 entries all adv dur 0 -> song_done after idx 31; rom_addr never returns to {song,0}.
REQ-045 Scenario, reset mid-ISSUE with voice_available=1 -> load_new_note=0 that cycle; all outputs 0 next cycle.
